// File: rtl/lm75_ctrl_pkg.sv
// lm75_ctrl_pkg: shared FSM encoding, display digit constants and temperature helpers
package lm75_ctrl_pkg;
    localparam int TEMP_W = 9;
    localparam logic [3:0] SIGN_MINUS = 4'd10;
    localparam logic [3:0] SIGN_PLUS  = 4'd0;
    localparam logic [3:0] DEC_HALF   = 4'd5;
    localparam logic [3:0] DEC_ZERO   = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_CONVERT,
        ST_UPDATE,
        ST_WAIT_TICK
    } state_e;

    typedef struct packed {
        logic [3:0] sign;
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
        logic [3:0] dec;
    } disp_t;

    // -128.0 (9'h100) negates to itself, which reads correctly as unsigned 256
    function automatic logic [TEMP_W-1:0] temp_mag(input logic [TEMP_W-1:0] t);
        return t[TEMP_W-1] ? -t : t;
    endfunction
endpackage

// File: rtl/lm75_poll_ctrl_if.sv
// lm75_poll_ctrl_if: start/done handshake between the poll controller and the I2C read engine
interface lm75_poll_ctrl_if;
    logic        i2c_start;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_ack_err;
    logic [15:0] i2c_data;

    modport master (output i2c_start, input i2c_busy, i2c_done, i2c_ack_err, i2c_data);
    modport slave  (input i2c_start, output i2c_busy, i2c_done, i2c_ack_err, i2c_data);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit binary to 3 BCD digits by repeated subtraction, one step per cycle
module bin2bcd_seq (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] bin_i,
    output logic       done_o,
    output logic [3:0] hun_o,
    output logic [3:0] ten_o,
    output logic [3:0] one_o
);
    logic [7:0] rem_q;
    logic [3:0] hun_q, ten_q;
    logic       busy_q, done_q;

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            rem_q  <= '0;
            hun_q  <= '0;
            ten_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= bin_i;
                hun_q  <= '0;
                ten_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (rem_q >= 8'd100) begin
                    rem_q <= rem_q - 8'd100;
                    hun_q <= hun_q + 4'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_q <= rem_q - 8'd10;
                    ten_q <= ten_q + 4'd1;
                end else begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign hun_o  = hun_q;
    assign ten_o  = ten_q;
    assign one_o  = rem_q[3:0];
endmodule

// File: rtl/lm75_poll_ctrl.sv
// lm75_poll_ctrl: periodic LM75 read sequencer with retry/timeout and BCD display output; LM75_ALARM_EN adds the over-temperature alarm
module lm75_poll_ctrl
    import lm75_ctrl_pkg::*;
#(
    parameter int POLL_CYCLES    = 12_500_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRY      = 2
`ifdef LM75_ALARM_EN
    ,
    parameter logic signed [TEMP_W-1:0] T_OS   = 9'sd160,
    parameter logic signed [TEMP_W-1:0] T_HYST = 9'sd150
`endif
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    lm75_poll_ctrl_if.master        i2c,
    output logic [3:0]              sign,
    output logic [3:0]              hundreds,
    output logic [3:0]              tens,
    output logic [3:0]              ones,
    output logic [3:0]              decimal,
    output logic                    temp_valid,
    output logic                    upd,
    output logic                    err,
    output logic                    alarm
);
    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_e              state_q;
    logic [PW-1:0]       poll_q;
    logic [TW-1:0]       to_q;
    logic [RW-1:0]       retry_q;
    logic [TEMP_W-1:0]   temp_q;
    logic [TEMP_W-1:0]   mag_d;
    disp_t               disp_q;
    logic                start_q, bcd_go_q, upd_q, valid_q, err_q;
    logic                bcd_done;
    logic [3:0]          bcd_h, bcd_t, bcd_o;
    logic                unused_data;

    assign mag_d       = temp_mag(temp_q);
    assign unused_data = ^i2c.i2c_data[6:0];

    bin2bcd_seq u_bcd (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .start_i (bcd_go_q),
        .bin_i   (mag_d[TEMP_W-1:1]),
        .done_o  (bcd_done),
        .hun_o   (bcd_h),
        .ten_o   (bcd_t),
        .one_o   (bcd_o)
    );

`ifdef LM75_ALARM_EN
    logic alarm_q;
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n)
            alarm_q <= 1'b0;
        else if (state_q == ST_UPDATE)
            alarm_q <= ($signed(temp_q) >= T_OS) ? 1'b1 : ($signed(temp_q) < T_HYST) ? 1'b0 : alarm_q;
    end
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            poll_q   <= '0;
            to_q     <= '0;
            retry_q  <= '0;
            temp_q   <= '0;
            disp_q   <= '0;
            start_q  <= 1'b0;
            bcd_go_q <= 1'b0;
            upd_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            bcd_go_q <= 1'b0;
            upd_q    <= 1'b0;
            poll_q   <= (poll_q >= PW'(POLL_CYCLES - 1)) ? poll_q : poll_q + 1'b1;
            case (state_q)
                ST_IDLE: if (enable) state_q <= ST_START;
                ST_START: begin
                    if (!i2c.i2c_busy) begin
                        // the issuing cycle counts as 0 so pulses land exactly POLL_CYCLES apart
                        start_q <= 1'b1;
                        poll_q  <= PW'(1);
                        to_q    <= '0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    to_q <= to_q + 1'b1;
                    if (i2c.i2c_done && !i2c.i2c_ack_err) begin
                        temp_q   <= i2c.i2c_data[15:7];
                        bcd_go_q <= 1'b1;
                        state_q  <= ST_CONVERT;
                    end else if (i2c.i2c_done || to_q == TW'(TIMEOUT_CYCLES)) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= ST_START;
                        end else begin
                            err_q   <= 1'b1;
                            retry_q <= '0;
                            state_q <= ST_WAIT_TICK;
                        end
                    end
                end
                ST_CONVERT: if (bcd_done) state_q <= ST_UPDATE;
                ST_UPDATE: begin
                    disp_q  <= {temp_q[TEMP_W-1] ? SIGN_MINUS : SIGN_PLUS, bcd_h, bcd_t, bcd_o,
                                mag_d[0] ? DEC_HALF : DEC_ZERO};
                    upd_q   <= 1'b1;
                    valid_q <= 1'b1;
                    err_q   <= 1'b0;
                    retry_q <= '0;
                    state_q <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable)
                        state_q <= ST_IDLE;
                    else if (poll_q >= PW'(POLL_CYCLES - 1))
                        state_q <= ST_START;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign i2c.i2c_start = start_q;
    assign {sign, hundreds, tens, ones, decimal} = disp_q;
    assign temp_valid = valid_q;
    assign upd        = upd_q;
    assign err        = err_q;
endmodule

// File: tb/tb_lm75_poll_ctrl.sv
// tb_lm75_poll_ctrl: directed bench for lm75_poll_ctrl with a small read-engine BFM
module tb_lm75_poll_ctrl;
    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic       enable  = 1'b0;
    logic [3:0] sign, hundreds, tens, ones, decimal;
    logic       temp_valid, upd, err, alarm;

    int          cyc       = 0;
    int          total     = 0;
    int          bad       = 0;
    int          upd_cnt   = 0;
    int          start_cnt = 0;
    int          ack_errs  = 0;
    bit          silent    = 1'b0;
    bit          err_seen  = 1'b0;
    logic [15:0] resp      = 16'h0000;

`ifdef LM75_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    lm75_poll_ctrl_if i2c ();

    lm75_poll_ctrl #(
        .POLL_CYCLES    (200),
        .TIMEOUT_CYCLES (50),
        .MAX_RETRY      (2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .i2c        (i2c),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .decimal    (decimal),
        .temp_valid (temp_valid),
        .upd        (upd),
        .err        (err),
        .alarm      (alarm)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [19:0] exp);
        chk(tag, {12'h0, sign, hundreds, tens, ones, decimal}, {12'h0, exp});
    endtask

    function automatic logic [24:0] all_outs();
        return {sign, hundreds, tens, ones, decimal, temp_valid, upd, err, alarm, i2c.i2c_start};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_upd();
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!upd && n < 500);
        chk("upd_seen", upd, 1);
    endtask

    task automatic wait_start(output int c);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!i2c.i2c_start && n < 500);
        chk("start_seen", i2c.i2c_start, 1);
        c = cyc;
    endtask

    // read engine: busy for 5 cycles, then a done pulse unless told to stay silent
    initial begin
        i2c.i2c_busy    = 1'b0;
        i2c.i2c_done    = 1'b0;
        i2c.i2c_ack_err = 1'b0;
        i2c.i2c_data    = 16'h0000;
        forever begin
            @(negedge sys_clk);
            if (i2c.i2c_start) begin
                i2c.i2c_busy = 1'b1;
                repeat (5) @(negedge sys_clk);
                i2c.i2c_busy = 1'b0;
                if (!silent) begin
                    i2c.i2c_done    = 1'b1;
                    i2c.i2c_ack_err = ack_errs > 0;
                    i2c.i2c_data    = (ack_errs > 0) ? 16'hDEAD : resp;
                    if (ack_errs > 0) ack_errs--;
                    @(negedge sys_clk);
                    i2c.i2c_done    = 1'b0;
                    i2c.i2c_ack_err = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (i2c.i2c_start) start_cnt++;
            if (upd) upd_cnt++;
            if (err) err_seen = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int s1, s2, s3, u0, c0;
        settle(3);
        chk("reset_outs", {7'h0, all_outs()}, 0);

        rst_n  = 1'b0;
        resp   = 16'h1900;
        enable = 1'b1;
        wait_upd();
        chk_disp("p25", 20'h00250);
        chk("valid_set", temp_valid, 1);
        chk("err_idle", err, 0);
        @(negedge sys_clk);
        chk("upd_one_cycle", upd, 0);

        resp = 16'hFF80;
        wait_upd();
        chk_disp("m0p5", 20'hA0005);
        resp = 16'h8000;
        wait_upd();
        chk_disp("m128", 20'hA1280);
        resp = 16'h7D00;
        wait_upd();
        chk_disp("p125", 20'h01250);

        wait_start(s1);
        wait_start(s2);
        chk("period1", s2 - s1, 200);
        wait_start(s3);
        chk("period2", s3 - s2, 200);
        wait_upd();

        silent = 1'b1;
        wait_start(s1);
        wait_start(s2);
        chk("retry_gap1", s2 - s1, 52);
        wait_start(s3);
        chk("retry_gap2", s3 - s2, 52);
        chk("err_before_exhaust", err, 0);
        settle(52);
        chk("err_set", err, 1);
        chk_disp("hold_on_err", 20'h01250);
        chk("valid_hold", temp_valid, 1);
        c0 = start_cnt;
        settle(100);
        chk("no_fourth_try", start_cnt, c0);
        silent = 1'b0;
        resp   = 16'h1900;
        wait_upd();
        chk("err_cleared", err, 0);
        chk_disp("p25_again", 20'h00250);

        ack_errs = 1;
        resp     = 16'h0C80;
        settle(1);
        err_seen = 1'b0;
        u0       = upd_cnt;
        c0       = start_cnt;
        wait_upd();
        chk_disp("p12p5", 20'h00125);
        settle(20);
        chk("retry_upd_once", upd_cnt - u0, 1);
        chk("retry_starts", start_cnt - c0, 2);
        chk("retry_no_err", err_seen, 0);

        silent = 1'b1;
        wait_start(s1);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        #1;
        chk("rst_async", {7'h0, all_outs()}, 0);
        c0 = start_cnt;
        settle(20);
        chk("rst_no_start", start_cnt, c0);
        chk("rst_hold", {7'h0, all_outs()}, 0);
        silent = 1'b0;
        resp   = 16'h5000;
        rst_n  = 1'b0;

        wait_upd();
        chk_disp("p80", 20'h00800);
        chk("alarm80", alarm, ALARM_ON);
        resp = 16'h4C00;
        wait_upd();
        chk_disp("p76", 20'h00760);
        chk("alarm76", alarm, ALARM_ON);
        resp = 16'h4A80;
        wait_upd();
        chk_disp("p74p5", 20'h00745);
        chk("alarm74p5", alarm, 0);

        resp = 16'h1900;
        wait_start(s1);
        enable = 1'b0;
        wait_upd();
        chk_disp("disable_completes", 20'h00250);
        settle(1);
        c0 = start_cnt;
        settle(400);
        chk("disable_idle", start_cnt, c0);
        chk_disp("disable_hold", 20'h00250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
